fetch_ctrl: RTL and testbench

FETCH_CTRL -- requirements
Module: fetch_ctrl

---
 rtl/fetch_ctrl.sv | 139 +++++++++++++
 tb/tb_fetch_ctrl.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: reset vector, run, interrupt entry and halt.
// Drives the PC mux/load/enable, the memory address source and the IR flush,
// and tracks a single pending interrupt plus the global interrupt enable.
module fetch_ctrl #(
  parameter logic [1:0] RST_VEC_SEL = 2'b01,
  parameter logic [1:0] INT_VEC_SEL = 2'b10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       int_req,
  input  logic       stall,
  input  logic       redirect,
  input  logic [1:0] redirect_src,
  input  logic       hlt_dec,
  input  logic       rti,
  output logic [1:0] pc_src,
  output logic       pc_load,
  output logic       pc_en,
  output logic [1:0] addr_src,
  output logic       sf1,
  output logic       flush_IR,
  output logic       HLT,
  output logic       int_ack
);

  // state    | meaning
  // RST_VEC  | load PC from memory word at the reset vector, flush IR
  // RUN      | sequential fetch; redirects, halt and interrupt entry decided here
  // INT_PUSH | IR captures current PC as return address, interrupt acknowledged
  // INT_VEC  | load PC from memory word at the interrupt vector, flush IR
  // HALT     | PC frozen, IR flushed; leaves only for an enabled pending interrupt
  typedef enum logic [2:0] {
    RST_VEC  = 3'd0,
    RUN      = 3'd1,
    INT_PUSH = 3'd2,
    INT_VEC  = 3'd3,
    HALT     = 3'd4
  } state_t;

  localparam logic [1:0] PC_SRC_SEQ = 2'b00;
  localparam logic [1:0] PC_SRC_MEM = 2'b10;

  state_t state;
  state_t next_state;
  logic   int_q;
  logic   int_pending;
  logic   int_en;
  logic   int_edge;
  logic   enter_push;

  assign int_edge   = int_req & ~int_q;
  assign enter_push = (next_state == INT_PUSH) && (state != INT_PUSH);

  // State register; reset always restarts from the reset vector.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= RST_VEC;
    else      state <= next_state;
  end

  // Interrupt edge capture, pending flag and global enable.
  // Entering INT_PUSH wins over a coincident edge or rti, so that edge is absorbed.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      int_q       <= 1'b0;
      int_pending <= 1'b0;
      int_en      <= 1'b1;
    end else begin
      int_q <= int_req;
      if (enter_push) begin
        int_pending <= 1'b0;
        int_en      <= 1'b0;
      end else begin
        if (int_edge)                 int_pending <= 1'b1;
        if ((state == RUN) && rti)    int_en      <= 1'b1;
      end
    end
  end

  // Next-state and output decode; reset overrides outputs without a clock edge.
  always_comb begin
    next_state = state;
    pc_src     = 2'b00;
    pc_load    = 1'b0;
    pc_en      = 1'b0;
    addr_src   = 2'b00;
    sf1        = 1'b0;
    flush_IR   = 1'b0;
    HLT        = 1'b0;
    int_ack    = 1'b0;
    case (state)
      RST_VEC: begin
        addr_src   = RST_VEC_SEL;
        pc_src     = PC_SRC_MEM;
        pc_load    = 1'b1;
        flush_IR   = 1'b1;
        next_state = RUN;
      end
      RUN: begin
        pc_load  = redirect;
        pc_src   = redirect ? redirect_src : PC_SRC_SEQ;
        flush_IR = redirect;
        pc_en    = ~stall & ~redirect;
        if (redirect)                               next_state = RUN;
        else if (hlt_dec && !stall)                 next_state = HALT;
        else if (int_pending && int_en && !stall)   next_state = INT_PUSH;
        else                                        next_state = RUN;
      end
      INT_PUSH: begin
        sf1        = 1'b1;
        int_ack    = 1'b1;
        next_state = INT_VEC;
      end
      INT_VEC: begin
        addr_src   = INT_VEC_SEL;
        pc_src     = PC_SRC_MEM;
        pc_load    = 1'b1;
        flush_IR   = 1'b1;
        next_state = RUN;
      end
      HALT: begin
        HLT      = 1'b1;
        flush_IR = 1'b1;
        if (int_pending && int_en) next_state = INT_PUSH;
      end
      default: next_state = RST_VEC;
    endcase
    if (!rst) begin
      pc_src   = PC_SRC_MEM;
      pc_load  = 1'b0;
      pc_en    = 1'b0;
      addr_src = RST_VEC_SEL;
      sf1      = 1'b0;
      flush_IR = 1'b1;
      HLT      = 1'b0;
      int_ack  = 1'b0;
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: reset, run, redirect, interrupt entry,
// masking until rti, stall deferral, halt and reset abandoning a sequence.
module tb_fetch_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       int_req;
  logic       stall;
  logic       redirect;
  logic [1:0] redirect_src;
  logic       hlt_dec;
  logic       rti;
  logic [1:0] pc_src;
  logic       pc_load;
  logic       pc_en;
  logic [1:0] addr_src;
  logic       sf1;
  logic       flush_IR;
  logic       HLT;
  logic       int_ack;

  int n_cmp = 0;
  int n_err = 0;

  // Packed order: pc_src[1:0] pc_load pc_en addr_src[1:0] sf1 flush_IR HLT int_ack
  localparam logic [9:0] O_RST   = 10'b10_0_0_01_0_1_0_0;
  localparam logic [9:0] O_RSTV  = 10'b10_1_0_01_0_1_0_0;
  localparam logic [9:0] O_RUN   = 10'b00_0_1_00_0_0_0_0;
  localparam logic [9:0] O_STALL = 10'b00_0_0_00_0_0_0_0;
  localparam logic [9:0] O_RED01 = 10'b01_1_0_00_0_1_0_0;
  localparam logic [9:0] O_RED11 = 10'b11_1_0_00_0_1_0_0;
  localparam logic [9:0] O_PUSH  = 10'b00_0_0_00_1_0_0_1;
  localparam logic [9:0] O_IVEC  = 10'b10_1_0_10_0_1_0_0;
  localparam logic [9:0] O_HALT  = 10'b00_0_0_00_0_1_1_0;

  fetch_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .int_req      (int_req),
    .stall        (stall),
    .redirect     (redirect),
    .redirect_src (redirect_src),
    .hlt_dec      (hlt_dec),
    .rti          (rti),
    .pc_src       (pc_src),
    .pc_load      (pc_load),
    .pc_en        (pc_en),
    .addr_src     (addr_src),
    .sf1          (sf1),
    .flush_IR     (flush_IR),
    .HLT          (HLT),
    .int_ack      (int_ack)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [9:0] exp);
    logic [9:0] obs;
    #1;
    obs = {pc_src, pc_load, pc_en, addr_src, sf1, flush_IR, HLT, int_ack};
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    rst = 1'b0; int_req = 1'b0; stall = 1'b0; redirect = 1'b0;
    redirect_src = 2'b00; hlt_dec = 1'b0; rti = 1'b0;
    chk("reset_async", O_RST);
    tick(); tick();
    chk("reset_hold", O_RST);

    // release: one reset-vector cycle then sequential fetch
    rst = 1'b1;
    chk("rst_vec", O_RSTV);
    tick();
    chk("run", O_RUN);
    stall = 1'b1;
    chk("run_stall", O_STALL);
    stall = 1'b0;
    redirect = 1'b1; redirect_src = 2'b01;
    chk("redirect01", O_RED01);
    tick();
    redirect = 1'b0;
    chk("run_after_redirect", O_RUN);

    // interrupt in RUN
    int_req = 1'b1;
    chk("int_raise", O_RUN);
    tick();
    chk("int_pending_run", O_RUN);
    tick();
    chk("int_push", O_PUSH);
    tick();
    chk("int_vec", O_IVEC);
    tick();
    chk("run_after_int", O_RUN);

    // second edge before rti is held off
    int_req = 1'b0; tick();
    int_req = 1'b1; tick(); tick();
    chk("masked_int", O_RUN);
    tick();
    chk("masked_int2", O_RUN);
    rti = 1'b1; tick(); rti = 1'b0;
    chk("rti_enable", O_RUN);
    tick();
    chk("int_after_rti", O_PUSH);
    tick(); tick();
    chk("run_after_rti_int", O_RUN);
    int_req = 1'b0; rti = 1'b1; tick(); rti = 1'b0; tick();

    // interrupt edge under a 3-cycle stall
    stall = 1'b1; int_req = 1'b1;
    chk("stall1", O_STALL);
    tick();
    chk("stall2", O_STALL);
    tick();
    chk("stall3", O_STALL);
    stall = 1'b0;
    chk("stall_release", O_RUN);
    tick();
    chk("push_after_stall", O_PUSH);
    tick(); tick();
    chk("run_after_stall_int", O_RUN);
    rti = 1'b1; int_req = 1'b0; tick(); rti = 1'b0; tick();

    // redirect outranks a pending interrupt
    redirect = 1'b1; redirect_src = 2'b11; int_req = 1'b1;
    tick();
    chk("redirect_pending", O_RED11);
    redirect = 1'b0;
    tick();
    chk("push_after_redirect", O_PUSH);
    tick(); tick();
    chk("run_after_redir_int", O_RUN);
    rti = 1'b1; int_req = 1'b0; tick(); rti = 1'b0; tick();

    // halt deferred by stall, then interrupt wakes it
    stall = 1'b1; hlt_dec = 1'b1;
    tick();
    chk("hlt_stalled", O_STALL);
    stall = 1'b0;
    tick();
    hlt_dec = 1'b0;
    chk("halt", O_HALT);
    tick();
    chk("halt_hold", O_HALT);
    int_req = 1'b1;
    tick();
    chk("halt_pending", O_HALT);
    tick();
    chk("halt_exit_push", O_PUSH);
    tick();
    chk("halt_int_vec", O_IVEC);
    tick();
    chk("halt_run", O_RUN);

    // reset during INT_VEC abandons the interrupt
    rti = 1'b1; int_req = 1'b0; tick(); rti = 1'b0; tick();
    int_req = 1'b1; tick(); tick();
    chk("push_pre_rst", O_PUSH);
    tick();
    chk("ivec_pre_rst", O_IVEC);
    rst = 1'b0;
    chk("rst_in_ivec", O_RST);
    int_req = 1'b0;
    tick();
    chk("rst_in_ivec_hold", O_RST);
    rst = 1'b1;
    chk("rst_vec_again", O_RSTV);
    tick();
    chk("run_after_rst", O_RUN);
    tick();
    chk("no_stale_int", O_RUN);

    // reset while halted
    hlt_dec = 1'b1; tick(); hlt_dec = 1'b0;
    chk("halt_pre_rst", O_HALT);
    rst = 1'b0;
    chk("rst_in_halt", O_RST);
    tick();
    rst = 1'b1;
    chk("rst_vec_from_halt", O_RSTV);
    tick();
    chk("run_from_halt_rst", O_RUN);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
